// File: rtl/seg6_scan_driver.sv
// seg6_scan_driver
//   Six-digit, time-multiplexed common-anode seven-segment driver.
//   Each digit slot lasts SCAN_DIV cycles. The first cycle of every slot is
//   dark to suppress ghosting. The six digit codes are captured once per
//   frame so a digit cannot change partway through a frame. While flash is
//   held, the whole display blinks with a half-period of BLINK_FRAMES frames.
//
// Ports
//   clk        in   1  system clock, rising edge
//   clr        in   1  asynchronous active-high reset
//   d1..d6     in   4  display codes (0-9 digit, 4'hE 'E', others blank); d1 leftmost
//   unlocked   in   1  lights the decimal point on every digit
//   flash      in   1  lockout blink request
//   an         out  6  digit enables, active-low, bit 0 = d1
//   seg        out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp         out  1  decimal point, active-low
module seg6_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [3:0] d6,
  input  logic       unlocked,
  input  logic       flash,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_idx;
  logic [3:0]        r_snap [6];
  logic [FCNT_W-1:0] r_fcnt;
  logic              r_phase;

  logic       w_slot_end;
  logic       w_frame_wrap;
  logic       w_dark;
  logic [3:0] w_digit;
  logic [5:0] w_an_sel;

  function automatic logic [6:0] seg7_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hE:    s = 7'b0000110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign w_slot_end   = (r_cnt == CNT_LAST);
  assign w_frame_wrap = w_slot_end && (r_idx == 3'd5);
  // flash is used live so that dropping it un-darkens on the very next edge,
  // before the registered phase has had time to clear.
  assign w_dark       = (r_cnt == '0) || (r_phase && flash);
  assign w_an_sel     = ~(6'b000001 << r_idx);

  always_comb begin
    w_digit = 4'hF;
    case (r_idx)
      3'd0:    w_digit = r_snap[0];
      3'd1:    w_digit = r_snap[1];
      3'd2:    w_digit = r_snap[2];
      3'd3:    w_digit = r_snap[3];
      3'd4:    w_digit = r_snap[4];
      3'd5:    w_digit = r_snap[5];
      default: w_digit = 4'hF;
    endcase
  end

  // Scan position: slot counter and digit index.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Frame snapshot: all six codes captured on the same edge that wraps idx.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 6; i++) r_snap[i] <= 4'hF;
    end else if (w_frame_wrap) begin
      r_snap[0] <= d1;
      r_snap[1] <= d2;
      r_snap[2] <= d3;
      r_snap[3] <= d4;
      r_snap[4] <= d5;
      r_snap[5] <= d6;
    end
  end

  // Blink control: counts frame wraps while flash is held.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (!flash) begin
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_frame_wrap) begin
      if (r_fcnt == FCNT_LAST) begin
        r_fcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fcnt  <= r_fcnt + FCNT_W'(1);
      end
    end
  end

  // Registered outputs, one cycle behind the scan state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      an  <= 6'b111111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else if (w_dark) begin
      an  <= 6'b111111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= w_an_sel;
      seg <= seg7_decode(w_digit);
      dp  <= ~unlocked;
    end
  end

endmodule

// File: tb/tb_seg6_scan_driver.sv
module tb_seg6_scan_driver;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = 6 * SD;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] td [6];
  logic       unlocked = 1'b0;
  logic       flash = 1'b0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: time since reset release, captured digits, and
  // number of frame wraps seen while flash has been continuously high.
  int         m_t;
  logic [3:0] m_snap [6];
  int         m_wraps;
  logic [5:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  seg6_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .clr(clr),
    .d1(td[0]), .d2(td[1]), .d3(td[2]), .d4(td[3]), .d5(td[4]), .d6(td[5]),
    .unlocked(unlocked), .flash(flash),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s t=%0d got=%h expected=%h", tag, m_t, got, want);
    end
  endtask

  function automatic logic [6:0] ref_decode(input logic [3:0] c);
    case (c)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      4'hE: return 7'b0000110;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    m_t = 0;
    m_wraps = 0;
    for (int k = 0; k < 6; k++) m_snap[k] = 4'hF;
    exp_an = 6'h3F;
    exp_seg = 7'h7F;
    exp_dp = 1'b1;
  endtask

  // Called just after a falling edge with inputs already set for the next
  // rising edge; predicts the outputs after that edge and checks them at the
  // following falling edge.
  task automatic tick();
    int  slot_pos, digit;
    bit  ph, dark;
    slot_pos = m_t % SD;
    digit    = (m_t / SD) % 6;
    ph       = ((m_wraps / BF) % 2) == 1;
    dark     = (slot_pos == 0) || (ph && flash);
    exp_an   = dark ? 6'h3F : ~(6'd1 << digit);
    exp_seg  = dark ? 7'h7F : ref_decode(m_snap[digit]);
    exp_dp   = dark ? 1'b1 : ~unlocked;
    if (slot_pos == SD - 1 && digit == 5) begin
      for (int k = 0; k < 6; k++) m_snap[k] = td[k];
      if (flash) m_wraps++;
    end
    if (!flash) m_wraps = 0;
    m_t++;
    @(negedge clk);
    chk("an", {26'd0, an}, {26'd0, exp_an});
    chk("seg", {25'd0, seg}, {25'd0, exp_seg});
    chk("dp", {31'd0, dp}, {31'd0, exp_dp});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asserts clr partway through a cycle and expects an immediate dark display.
  task automatic async_reset();
    #2;
    clr = 1'b1;
    #1;
    chk("rst_an_async", {26'd0, an}, 32'h3F);
    chk("rst_seg_async", {25'd0, seg}, 32'h7F);
    chk("rst_dp_async", {31'd0, dp}, 32'h1);
    @(negedge clk);
    chk("rst_an_held", {26'd0, an}, 32'h3F);
    clr = 1'b0;
    model_reset();
  endtask

  initial begin
    for (int k = 0; k < 6; k++) td[k] = 4'(k + 1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", {26'd0, an}, 32'h3F);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'h1);
    clr = 1'b0;
    model_reset();

    // First frame after release: nothing is lit.
    for (int i = 0; i < FRAME; i++) begin
      tick();
      chk("first_frame_seg", {25'd0, seg}, 32'h7F);
    end
    // Digits 1..6.
    run(2 * FRAME);

    // 'E' and an invalid code.
    td[2] = 4'hE;
    td[3] = 4'hB;
    run(2 * FRAME);

    // Mid-frame change of d1 must wait for the next frame.
    td[0] = 4'd7;
    run(FRAME);
    run(3 * SD + 2);
    td[0] = 4'd8;
    run(FRAME - 3 * SD - 2 + FRAME);

    // Decimal point toggled mid-slot.
    unlocked = 1'b1;
    run(5);
    unlocked = 1'b0;
    run(6);
    unlocked = 1'b1;
    run(FRAME);

    // Blink from a frame boundary, then drop flash inside a dark frame.
    while (m_t % FRAME != 0) tick();
    flash = 1'b1;
    run(4 * FRAME);
    run(2 * FRAME + 10);
    flash = 1'b0;
    run(FRAME);

    // Mid-frame asynchronous reset.
    run(7);
    async_reset();
    run(FRAME + 3);

    // Randomized traffic.
    for (int i = 0; i < 2400; i++) begin
      if ($urandom_range(0, 7) == 0) td[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) unlocked = ~unlocked;
      if ($urandom_range(0, 59) == 0) flash = ~flash;
      if (i == 1300) async_reset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg6_scan_driver.md
# seg6_scan_driver

Time-multiplexed six-digit seven-segment display driver. It sits directly downstream of the six-digit lock controller and consumes its six BCD display nibbles (`out1`–`out6`), the compare result (`res`) and the error-lockout flash request (`led`). It drives common-anode digit enables and segment lines with three features: a per-frame snapshot of the digits, a blanking slot between digits to stop ghosting, and whole-display blinking during lockout.

## Interface
Parameters:
- `SCAN_DIV`, default 50000 — clock cycles per digit slot; legal range ≥2.
- `BLINK_FRAMES`, default 16 — full scan frames per blink half-period; legal range ≥1.

Ports:
- `clk`  in  1 — system clock (the free-running board clock); all state updates on its rising edge.
- `clr`  in  1 — reset, asynchronous, active-high.
- `d1`..`d6`  in  4 each — display nibbles; `d1` is the leftmost digit. 0–9 show the digit, 4'b1110 shows 'E', every other code shows blank.
- `unlocked`  in  1 — lights the decimal point on all digits.
- `flash`  in  1 — lockout blink request.
- `an`  out  6 — digit enables, active-low; bit 0 is `d1`.
- `seg`  out  7 — segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1 — decimal point, active-low.

## Operation
- State:
  - `cnt`: 0..SCAN_DIV-1.
  - `idx`: 0..5.
  - `snap[0..5]`: 4-bit snapshot registers.
  - `fcnt`: 0..BLINK_FRAMES-1.
  - `phase`: 1 bit.
- Slot counter: `cnt` increments every cycle. At `cnt`==SCAN_DIV-1 it wraps to 0 and `idx` advances. `idx` wraps 5→0.
- Frame snapshot: on the edge where `idx` goes 5→0, all six `snap` registers load `d1`..`d6` together. Digit changes mid-frame never appear until the next frame.
- Blanking slot: while `cnt`==0 the display is dark: `an`=6'b111111, `seg`=7'b1111111, `dp`=1.
- Active slot (`cnt`≥1):
  - `an` has only bit `idx` low.
  - `seg` is the decode of `snap[idx]`.
  - `dp` = ~`unlocked`.
- Decode table (active-low, {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, E=0000110; anything else 1111111.
- Blink control:
  - While `flash`=0: `fcnt`=0 and `phase`=0.
  - While `flash`=1: `fcnt` increments at each frame wrap (`idx` 5→0). When it reaches BLINK_FRAMES-1 and a further frame wrap occurs, it returns to 0 and `phase` toggles.
  - When `phase`=1 the display is dark (same as the blanking slot). Scanning and snapshots continue underneath.
- Dropping `flash` mid-dark-phase restores the display on the next cycle, subject to the output register delay below.
- `unlocked` and `flash` are sampled live, not snapshotted.

## Timing
- Reset (`clr`=1, asynchronous):
  - `cnt`=0, `idx`=0, `fcnt`=0, `phase`=0.
  - `snap[*]`=4'b1111, which decodes to blank.
  - Outputs: `an`=6'b111111, `seg`=7'b1111111, `dp`=1.
- After reset release, the first frame is blank. Digits appear after the first 5→0 wrap, i.e. 6·SCAN_DIV cycles after release.
- `an`, `seg` and `dp` are registered. The value presented in cycle n+1 is computed from `cnt`, `idx`, `snap`, `phase`, `unlocked` and `flash` in cycle n (1-cycle latency).
- Each digit is lit for SCAN_DIV-1 cycles out of every SCAN_DIV. Frame period = 6·SCAN_DIV cycles.
- Simultaneous events:
  - Snapshot load, `idx` wrap and `fcnt` advance all occur on the same edge.
  - The first active slot of the new frame shows the new `snap[0]`.
- `clr` asserted mid-frame forces the outputs dark immediately (asynchronous) and restarts at `idx`=0.
- No handshake: the inputs are level signals that are already synchronous to `clk`.

## Test plan
Use SCAN_DIV=4, BLINK_FRAMES=2.
- Reset check: pulse `clr` mid-slot → outputs become 111111 / 1111111 / 1 within the same cycle; the first 24 cycles after release stay dark.
- Digit decode: `d1`..`d6`=1,2,3,4,5,6 held → in frame 2, each slot shows one blank cycle, then three cycles of `an`=~(1<<idx) with `seg`=1111001, 0100100, 0110000, 0011001, 0010010, 0000010 in order.
- Error and invalid codes: `d3`=4'hE, `d4`=4'hB → slot 2 shows `seg`=0000110; slot 3 shows `an` low with `seg`=1111111.
- Tear-free update: change `d1` from 7 to 8 during slot 3 → slots 0–5 of the current frame keep showing 7; the next frame shows 8 (`seg`=0000000).
- Blink: raise `flash` at a frame boundary → 2 frames lit, 2 frames fully dark (`an`=111111), repeating. Dropping `flash` during a dark frame restores the display one cycle later.
- Decimal point: toggle `unlocked` mid-slot → `dp` follows one cycle later on active cycles and stays 1 during blanking slots.
